// File: rtl/expr_pkg.sv
// Shared definitions for the ASCII expression stream blocks (recognizer and evaluator).
// Holds the FSM state encoding, the ASCII character constants and the
// character-class enumeration.
package expr_pkg;

  // 4-bit state encoding shared with the recognizer.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_OPND = 4'd1,
    ST_OPR  = 4'd2,
    ST_ERR  = 4'd3
  } state_e;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2b;
  localparam logic [7:0] CH_MUL  = 8'h2a;
  localparam logic [7:0] CH_EQ   = 8'h3d;

  typedef enum logic [2:0] {
    CLS_DIG = 3'd0,
    CLS_ADD = 3'd1,
    CLS_MUL = 3'd2,
    CLS_EQ  = 3'd3,
    CLS_OTH = 3'd4
  } cls_e;

endpackage

// File: rtl/char_class.sv
// Combinational character classifier for the expression stream.
// Ports:
//   ch_i  - ASCII character
//   cls_o - character class (digit, '+', '*', '=', other)
//   dig_o - digit value 0..9 when cls_o is CLS_DIG, else 0
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch_i,
  output cls_e       cls_o,
  output logic [3:0] dig_o
);

  always_comb begin
    cls_o = CLS_OTH;
    dig_o = 4'd0;
    if (ch_i >= CH_0 && ch_i <= CH_9) begin
      cls_o = CLS_DIG;
      dig_o = 4'(ch_i - CH_0);
    end else begin
      case (ch_i)
        CH_PLUS: cls_o = CLS_ADD;
        CH_MUL:  cls_o = CLS_MUL;
        CH_EQ:   cls_o = CLS_EQ;
        default: cls_o = CLS_OTH;
      endcase
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Evaluator for the ASCII expression stream digit (('+'|'*') digit)* '='.
// '*' binds tighter than '+'; arithmetic is modulo 2^W.
// Ports:
//   clk          - clock, rising edge
//   clr          - asynchronous active-high reset
//   in_valid     - character strobe
//   in           - ASCII character
//   result       - expression value, nonzero only while result_valid
//   result_valid - one-cycle pulse one clock after '=' is sampled
//   error        - syntax error for the emitted expression
//   overflow     - some intermediate or final value exceeded 2^W-1
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         error,
  output logic         overflow
);

  cls_e       cls;
  logic [3:0] dig;

  char_class u_char_class (
    .ch_i  (in),
    .cls_o (cls),
    .dig_o (dig)
  );

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic         mul_pend_q, mul_pend_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] result_q, result_d;
  logic         rvalid_q, rvalid_d;
  logic         err_q, err_d;
  logic         ovfo_q, ovfo_d;

  // Widened datapath: any bit above W-1 flags overflow.
  logic [W+3:0] prod, tot;
  logic         prod_ovf, tot_ovf;
  logic         emit, emit_err;

  assign prod     = (W+4)'(term_q) * (W+4)'(dig);
  assign tot      = (W+4)'(sum_q) + (W+4)'(term_q);
  assign prod_ovf = |prod[W+3:W];
  assign tot_ovf  = |tot[W+3:W];

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_d     = term_q;
    mul_pend_d = mul_pend_q;
    ovf_d      = ovf_q;
    result_d   = '0;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    ovfo_d     = 1'b0;
    emit       = 1'b0;
    emit_err   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          case (cls)
            CLS_DIG: begin
              term_d     = W'(dig);
              sum_d      = '0;
              mul_pend_d = 1'b0;
              ovf_d      = 1'b0;
              state_d    = ST_OPR;
            end
            CLS_EQ: begin
              emit     = 1'b1;
              emit_err = 1'b1;
            end
            default: state_d = ST_ERR;
          endcase
        end
        ST_OPND: begin
          case (cls)
            CLS_DIG: begin
              if (mul_pend_q) begin
                term_d = prod[W-1:0];
                ovf_d  = ovf_q | prod_ovf;
              end else begin
                term_d = W'(dig);
              end
              state_d = ST_OPR;
            end
            CLS_EQ: begin
              emit     = 1'b1;
              emit_err = 1'b1;
            end
            default: state_d = ST_ERR;
          endcase
        end
        ST_OPR: begin
          case (cls)
            CLS_ADD: begin
              sum_d      = tot[W-1:0];
              ovf_d      = ovf_q | tot_ovf;
              mul_pend_d = 1'b0;
              state_d    = ST_OPND;
            end
            CLS_MUL: begin
              mul_pend_d = 1'b1;
              state_d    = ST_OPND;
            end
            CLS_EQ:  emit = 1'b1;
            default: state_d = ST_ERR;
          endcase
        end
        ST_ERR: begin
          if (cls == CLS_EQ) begin
            emit     = 1'b1;
            emit_err = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Emission also wipes the accumulators so the next digit starts clean.
    if (emit) begin
      rvalid_d   = 1'b1;
      err_d      = emit_err;
      result_d   = emit_err ? '0 : tot[W-1:0];
      ovfo_d     = emit_err ? 1'b0 : (ovf_q | tot_ovf);
      sum_d      = '0;
      term_d     = '0;
      mul_pend_d = 1'b0;
      ovf_d      = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      term_q     <= '0;
      mul_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      ovfo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      mul_pend_q <= mul_pend_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      ovfo_q     <= ovfo_d;
    end
  end

  assign result       = result_q;
  assign result_valid = rvalid_q;
  assign error        = err_q;
  assign overflow     = ovfo_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: table of directed expressions, reset corner cases, and random
// expressions checked against a string-level evaluator.
module tb_expr_eval;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_ch = 8'h00;
  logic [W-1:0] result;
  logic         result_valid, error, overflow;

  expr_eval #(.W(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .in_valid     (in_valid),
    .in           (in_ch),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] res;
    bit           err;
    bit           ovf;
  } exp_t;

  typedef struct {
    string        s;
    int           gap;
    logic [W-1:0] res;
    bit           err;
    bit           ovf;
  } vec_t;

  exp_t  expq[$];
  string buf_s = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: parse the whole expression text, track overflow on every product and sum.
  function automatic void model(input string s, output logic [W-1:0] r, output bit e,
                                output bit o);
    longint lim = longint'(1) << W;
    longint sum = 0;
    longint term;
    byte    c;
    e = (s.len() % 2 == 0);
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (i % 2 == 0) begin
        if (c < 8'h30 || c > 8'h39) e = 1;
      end else if (c != 8'h2b && c != 8'h2a) begin
        e = 1;
      end
    end
    r = '0;
    o = 0;
    if (e) return;
    term = longint'(s[0]) - 48;
    for (int i = 1; i < s.len(); i += 2) begin
      longint d = longint'(s[i+1]) - 48;
      if (s[i] == 8'h2a) begin
        term = term * d;
        if (term >= lim) o = 1;
        term = term % lim;
      end else begin
        sum = sum + term;
        if (sum >= lim) o = 1;
        sum  = sum % lim;
        term = d;
      end
    end
    sum = sum + term;
    if (sum >= lim) o = 1;
    r = W'(sum % lim);
  endfunction

  // Drive one character for one cycle, then `gap` idle cycles. On '=' the expected
  // pulse is queued for the cycle after it is sampled.
  task automatic send_char(input byte c, input int gap, input bit use_tab, input vec_t tv);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = c;
    if (!clr) begin
      if (c == 8'h3d) begin
        if (use_tab) begin
          e.res = tv.res; e.err = tv.err; e.ovf = tv.ovf;
        end else begin
          model(buf_s, e.res, e.err, e.ovf);
        end
        e.cyc = cyc + 1;
        expq.push_back(e);
        buf_s = "";
      end else begin
        buf_s = $sformatf("%s%c", buf_s, c);
      end
    end
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_ch    = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_ch    = 8'($urandom);
    end
  endtask

  task automatic send_str(input string s, input int gap, input bit use_tab, input vec_t tv);
    for (int i = 0; i < s.len(); i++) send_char(s[i], gap, use_tab, tv);
  endtask

  // Every cycle: either the queued pulse is due, or all outputs must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      chk("result_valid", 32'(result_valid), 32'd1);
      chk("result", 32'(result), 32'(e.res));
      chk("error", 32'(error), 32'(e.err));
      chk("overflow", 32'(overflow), 32'(e.ovf));
    end else begin
      chk("quiet_outputs", {13'd0, result_valid, error, overflow, result}, 32'd0);
    end
  end

  vec_t tab[12];
  vec_t none;

  initial begin
    tab[0]  = '{"3+4*5=", 0, 16'd23, 1'b0, 1'b0};
    tab[1]  = '{"2*3*4+1=", 2, 16'd25, 1'b0, 1'b0};
    tab[2]  = '{"3++4=", 0, 16'd0, 1'b1, 1'b0};
    tab[3]  = '{"7=", 0, 16'd7, 1'b0, 1'b0};
    tab[4]  = '{"=", 0, 16'd0, 1'b1, 1'b0};
    tab[5]  = '{"5+=", 0, 16'd0, 1'b1, 1'b0};
    tab[6]  = '{"9*9*9*9*9*9=", 0, 16'd7153, 1'b0, 1'b1};
    tab[7]  = '{"1=", 0, 16'd1, 1'b0, 1'b0};
    tab[8]  = '{"9*9*9*9*9+9*9*9*9*9=", 0, 16'd52562, 1'b0, 1'b1};
    tab[9]  = '{"4a=", 1, 16'd0, 1'b1, 1'b0};
    tab[10] = '{"5*0+8=", 0, 16'd8, 1'b0, 1'b0};
    tab[11] = '{"8*8+2*3+0=", 0, 16'd70, 1'b0, 1'b0};
    none    = '{"", 0, 16'd0, 1'b0, 1'b0};

    // Reset held with traffic present: outputs must stay quiet.
    idle(2);
    send_str("7=", 0, 1'b0, none);
    idle(1);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 12; i++) send_str(tab[i].s, tab[i].gap, 1'b1, tab[i]);
    idle(3);

    // Async clear mid-expression: "5+6" is discarded.
    send_str("5+6", 0, 1'b0, none);
    idle(1);
    @(posedge clk);
    #2 clr = 1'b1;
    buf_s = "";
    #1 chk("async_clr_quiet", {13'd0, result_valid, error, overflow, result}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    send_str("7=", 0, 1'b1, tab[3]);
    idle(2);

    // clr held while characters stream in.
    @(negedge clk);
    clr = 1'b1;
    send_str("9*9=", 0, 1'b0, none);
    idle(2);
    clr   = 1'b0;
    buf_s = "";
    send_str("4*2=", 0, 1'b1, '{"", 0, 16'd8, 1'b0, 1'b0});
    idle(2);

    // Random expressions, back-to-back, with occasional gaps and junk characters.
    for (int n = 0; n < 300; n++) begin
      string s = "";
      int    ops = $urandom_range(0, 6);
      s = $sformatf("%c", 8'h30 + 8'($urandom_range(0, 9)));
      for (int k = 0; k < ops; k++)
        s = $sformatf("%s%c%c", s, ($urandom_range(0, 1) != 0) ? 8'h2a : 8'h2b,
                      8'h30 + 8'($urandom_range(0, 9)));
      if ($urandom_range(0, 9) == 0) begin
        int  pos  = $urandom_range(0, s.len() - 1);
        byte junk = 8'($urandom_range(0, 255));
        s[pos] = junk;
      end
      s = {s, "="};
      for (int i = 0; i < s.len(); i++)
        send_char(s[i], ($urandom_range(0, 4) == 0) ? 1 : 0, 1'b0, none);
    end
    idle(4);

    chk("pending_pulses", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
